thor2023_dcache_fill_ctrl: RTL and testbench
============================================

Name: thor2023_dcache_fill_ctrl

Overview:
Sequences data-cache line fills for the Thor2023 L1 data cache after a load/store miss.
- Fetches one or two 32-byte half-lines (even/odd bank pair) over a Wishbone classic-cycle read bus.
- Assembles 128-bit beats into a 256-bit line and drives a single-cycle write strobe, line address and line data into the cache tag/valid/data arrays.
- Sits between the memory-stage miss logic and the bus interface unit.

Parameters:
BUS_WID, 128, Wishbone data width in bits; fixed at 2 beats per line.
LINE_WID, 256, cache half-line data width in bits (32 bytes).
AWID, 32, address width.
TO_CYCLES, 1023, bus-ack timeout in cycles per beat.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
miss_req  in  1  fill request; sampled only in IDLE
miss_adr  in  AWID  faulting address, any byte alignment
miss_both  in  1  access straddles two half-lines; fetch both
miss_ack  out  1  one-cycle pulse when fill sequence completes (ok or error)
busy  out  1  high in every state except IDLE
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
adr_o  out  AWID  beat address, 16-byte aligned
sel_o  out  16  byte selects; all ones whenever stb_o is high
ack_i  in  1  Wishbone acknowledge
err_i  in  1  Wishbone bus error
dat_i  in  BUS_WID  read data
dc_wr  out  1  one-cycle cache write strobe
dc_wadr  out  AWID  line address for dc_wr, 32-byte aligned
dc_wdat  out  LINE_WID  assembled line; beat0 in [127:0], beat1 in [255:128]
fill_err  out  1  sticky error flag; cleared on next accepted miss_req
abort  in  1  cache invalidate-all; cancels fill

Behaviour:
- Reset values: all outputs 0, state IDLE, beat counter 0, timeout counter 0.
- States: IDLE, BEAT0, BEAT1, WRITE, ERR.
- IDLE:
  - On miss_req, latch line0 = {miss_adr[AWID-1:5],5'b0} and both = miss_both.
  - Clear fill_err, go to BEAT0 next cycle.
  - cyc_o/stb_o assert in the first BEAT0 cycle.
- BEAT0:
  - Drive adr_o = line | 16'h0 with cyc_o = stb_o = 1.
  - On ack_i, capture dat_i into the low half and drop stb_o for one cycle (classic cycle, no pipelining).
  - Go to BEAT1.
- BEAT1:
  - adr_o = line | 5'h10.
  - On ack_i, capture the high half and deassert cyc_o/stb_o.
  - Go to WRITE.
- WRITE:
  - dc_wr = 1 for exactly one cycle; dc_wadr = current line; dc_wdat = assembled data.
  - If both and this was line0: line = line0 + 32 (bits [AWID-1:5] increment, wrapping modulo 2^AWID), go to BEAT0.
  - Otherwise pulse miss_ack and go to IDLE.
- Fill latency, zero-wait bus: single line 6 cycles from miss_req to miss_ack; two lines 11 cycles.
- err_i during any beat:
  - Drop cyc_o/stb_o, set fill_err, go to ERR.
  - No dc_wr for the faulting line; an already-written line0 remains.
  - ERR pulses miss_ack for one cycle, then returns to IDLE.
- Timeout: a counter resets at the start of each beat and increments while stb_o is high and ack_i is low. Reaching TO_CYCLES is treated as err_i.
- ack_i and err_i in the same cycle: err_i wins.
- ack_i outside an active strobe is ignored.
- abort in any non-IDLE state:
  - Drop the bus immediately, suppress a pending dc_wr, go to IDLE.
  - No miss_ack, fill_err unchanged.
  - abort in the WRITE cycle blocks dc_wr.
- miss_req while busy is ignored; the requester holds it until miss_ack.
- Asynchronous rst mid-fill returns all outputs to reset values immediately. No dc_wr is emitted.

Test Plan:
- Single fill: miss_adr=0x0000_1234, miss_both=0, zero-wait ack.
  - Expect adr_o=0x1220 then 0x1230, dc_wr once with dc_wadr=0x1220 and dc_wdat={beat1,beat0}.
  - miss_ack at cycle 6.
- Straddle: miss_adr=0x0000_13F8, miss_both=1.
  - Expect dc_wr at 0x13E0 then 0x1400, miss_ack at cycle 11.
- Wrap: miss_adr=0xFFFF_FFF0, miss_both=1.
  - Expect second line 0x0000_0000, beats 0x0 and 0x10.
- Error on second line beat1 (err_i=1):
  - Expect one dc_wr (line0), fill_err=1, miss_ack pulse.
  - Next miss_req clears fill_err.
- Timeout: ack_i never asserted.
  - Expect cyc_o drop after 1023 stalled cycles, fill_err=1, miss_ack, no dc_wr.
- Abort in WRITE cycle and async rst during BEAT1:
  - Expect no dc_wr, no miss_ack, cyc_o=0, busy=0 by the next edge (immediately for rst).

Source files
------------

// File: rtl/thor2023_dcache_fill_ctrl_if.sv
// thor2023_dcache_fill_ctrl_if: miss request, Wishbone read bus and cache write port of the fill controller
interface thor2023_dcache_fill_ctrl_if #(
  parameter int AWID = 32,
  parameter int BUS_WID = 128,
  parameter int LINE_WID = 256
);
  logic miss_req;
  logic [AWID-1:0] miss_adr;
  logic miss_both;
  logic miss_ack;
  logic busy;
  logic cyc_o;
  logic stb_o;
  logic [AWID-1:0] adr_o;
  logic [BUS_WID/8-1:0] sel_o;
  logic ack_i;
  logic err_i;
  logic [BUS_WID-1:0] dat_i;
  logic dc_wr;
  logic [AWID-1:0] dc_wadr;
  logic [LINE_WID-1:0] dc_wdat;
  logic fill_err;
  logic abort;
  modport master (
    input miss_req, miss_adr, miss_both, ack_i, err_i, dat_i, abort,
    output miss_ack, busy, cyc_o, stb_o, adr_o, sel_o, dc_wr, dc_wadr, dc_wdat, fill_err
  );
  modport slave (
    output miss_req, miss_adr, miss_both, ack_i, err_i, dat_i, abort,
    input miss_ack, busy, cyc_o, stb_o, adr_o, sel_o, dc_wr, dc_wadr, dc_wdat, fill_err
  );
endinterface

// File: rtl/thor2023_dcache_fill_ctrl.sv
// thor2023_dcache_fill_ctrl: fetches one or two 32-byte half-lines over Wishbone classic and writes them into the dcache
module thor2023_dcache_fill_ctrl #(
  parameter int BUS_WID = 128,
  parameter int LINE_WID = 256,
  parameter int AWID = 32,
  parameter int TO_CYCLES = 1023
) (
  input logic clk,
  input logic rst,
  thor2023_dcache_fill_ctrl_if.master bus
);
  localparam int TW = $clog2(TO_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, WRITE, ERR} state_t;
  state_t state_q, state_d;
  logic [1:0] ph_q, ph_d;
  logic [AWID-6:0] line_q, line_d;
  logic both_q, both_d, sec_q, sec_d, ferr_q, ferr_d;
  logic [LINE_WID-1:0] dat_q, dat_d;
  logic [TW-1:0] to_q, to_d;
  logic cyc, stb, fail, hit, wr;
  // ph_q: in BEAT1 0 is the strobe-low gap; in WRITE 0 settle, 1 write, 2 acknowledge
  assign cyc = !bus.abort && (state_q == BEAT0 || state_q == BEAT1);
  assign stb = cyc && (state_q == BEAT0 || ph_q != 2'd0);
  assign fail = stb && (bus.err_i || (!bus.ack_i && to_q == TW'(TO_CYCLES - 1)));
  assign hit = stb && bus.ack_i && !fail;
  assign wr = !bus.abort && state_q == WRITE && ph_q == 2'd1;
  assign to_d = (stb && !bus.ack_i) ? to_q + TW'(1) : '0;
  always_comb begin
    state_d = state_q;
    ph_d = ph_q;
    line_d = line_q;
    both_d = both_q;
    sec_d = sec_q;
    ferr_d = ferr_q;
    dat_d = dat_q;
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      ph_d = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.miss_req) begin
          line_d = bus.miss_adr[AWID-1:5];
          both_d = bus.miss_both;
          sec_d = 1'b0;
          ferr_d = 1'b0;
          ph_d = '0;
          state_d = BEAT0;
        end
        BEAT0, BEAT1: begin
          if (state_q == BEAT1) ph_d = 2'd1;
          if (fail) begin
            state_d = ERR;
            ferr_d = 1'b1;
            ph_d = '0;
          end else if (hit) begin
            if (state_q == BEAT0) dat_d[BUS_WID-1:0] = bus.dat_i;
            else dat_d[LINE_WID-1:BUS_WID] = bus.dat_i;
            state_d = (state_q == BEAT0) ? BEAT1 : WRITE;
            ph_d = '0;
          end
        end
        WRITE: begin
          ph_d = ph_q + 2'd1;
          if (ph_q == 2'd1 && both_q && !sec_q) begin
            line_d = line_q + (AWID-5)'(1);
            sec_d = 1'b1;
            ph_d = '0;
            state_d = BEAT0;
          end else if (ph_q == 2'd2) begin
            ph_d = '0;
            state_d = IDLE;
          end
        end
        default: begin
          ph_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q <= '0;
      line_q <= '0;
      both_q <= 1'b0;
      sec_q <= 1'b0;
      ferr_q <= 1'b0;
      dat_q <= '0;
      to_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      line_q <= line_d;
      both_q <= both_d;
      sec_q <= sec_d;
      ferr_q <= ferr_d;
      dat_q <= dat_d;
      to_q <= to_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.cyc_o = cyc;
  assign bus.stb_o = stb;
  assign bus.sel_o = {(BUS_WID/8){stb}};
  assign bus.adr_o = cyc ? {line_q, state_q == BEAT1, 4'b0} : '0;
  assign bus.dc_wr = wr;
  assign bus.dc_wadr = wr ? {line_q, 5'b0} : '0;
  assign bus.dc_wdat = wr ? dat_q : '0;
  assign bus.miss_ack = !bus.abort && (state_q == ERR || (state_q == WRITE && ph_q == 2'd2));
  assign bus.fill_err = ferr_q;
endmodule

// File: tb/tb_thor2023_dcache_fill_ctrl.sv
// tb_thor2023_dcache_fill_ctrl: directed fills against a cycle-timeline model of the fill controller
module tb_thor2023_dcache_fill_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  thor2023_dcache_fill_ctrl_if bus ();
  thor2023_dcache_fill_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  logic stall = 1'b0, junk_ack = 1'b0, err_en = 1'b0;
  logic [31:0] err_adr = '0;
  function automatic logic [127:0] beat(input logic [31:0] a);
    return {a, a + 32'd1, a + 32'd2, a + 32'd3};
  endfunction
  // zero-wait slave: data is a function of the beat address
  assign bus.ack_i = (bus.stb_o && !stall) || junk_ack;
  assign bus.err_i = bus.stb_o && err_en && bus.adr_o == err_adr;
  assign bus.dat_i = beat(bus.adr_o);
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  int n_wr = 0, n_ack = 0, n_cyc = 0;
  logic [31:0] wq[$];
  logic [255:0] last_wdat = '0;
  bit m_on = 0;
  int m_k = 0, m_n = 1, ack_k = 0, ci = 0, cp = 0, last = 0;
  bit inl = 0;
  logic [31:0] m_line[2];
  // timeline per line, 1-based cycles after accept: strobe at 1 and 3, write at 5, ack after the last line
  always @(negedge clk) begin
    if (bus.dc_wr) begin
      n_wr++;
      wq.push_back(bus.dc_wadr);
      last_wdat = bus.dc_wdat;
    end
    if (bus.miss_ack) n_ack++;
    if (bus.cyc_o) n_cyc++;
    if (m_on) begin
      m_k++;
      last = 5 * m_n + 1;
      if (m_k == 0) begin
        chk("idle_busy", bus.busy, 0);
        chk("idle_cyc", bus.cyc_o, 0);
      end else begin
        ci = (m_k - 1) / 5;
        cp = (m_k - 1) % 5;
        inl = m_k <= 5 * m_n;
        chk("busy", bus.busy, m_k <= last);
        chk("cyc", bus.cyc_o, inl && cp <= 2);
        chk("stb", bus.stb_o, inl && (cp == 0 || cp == 2));
        chk("dc_wr", bus.dc_wr, inl && cp == 4);
        chk("miss_ack", bus.miss_ack, m_k == last);
        chk("fill_err", bus.fill_err, 0);
        if (inl && (cp == 0 || cp == 2)) begin
          chk("adr_o", bus.adr_o, m_line[ci] + (cp == 2 ? 32'd16 : 32'd0));
          chk("sel_o", bus.sel_o, 16'hFFFF);
        end
        if (inl && cp == 4) begin
          chk("dc_wadr", bus.dc_wadr, m_line[ci]);
          chk("dc_wdat", bus.dc_wdat, {beat(m_line[ci] + 32'd16), beat(m_line[ci])});
        end
        if (bus.miss_ack) ack_k = m_k;
        if (m_k > last) m_on = 0;
      end
    end
  end
  task automatic wait_ack(input int lim);
    int c = 0;
    while (!bus.miss_ack && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk("ack_seen", bus.miss_ack, 1);
  endtask
  task automatic start(input logic [31:0] a, input logic b);
    @(posedge clk);
    #1;
    bus.miss_adr = a;
    bus.miss_both = b;
    bus.miss_req = 1'b1;
  endtask
  task automatic drop_req();
    @(posedge clk);
    #1 bus.miss_req = 1'b0;
  endtask
  task automatic fill(input logic [31:0] a, input logic b);
    int c = 0;
    m_line[0] = a & ~32'd31;
    m_line[1] = m_line[0] + 32'd32;
    m_n = b ? 2 : 1;
    ack_k = 0;
    start(a, b);
    m_k = -1;
    m_on = 1;
    wait_ack(20);
    drop_req();
    while (m_on && c < 5) begin
      @(negedge clk);
      c++;
    end
  endtask
  int w0 = 0, a0 = 0, c0 = 0;
  initial begin
    bus.miss_req = 1'b0;
    bus.miss_adr = '0;
    bus.miss_both = 1'b0;
    bus.abort = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_cyc", bus.cyc_o, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.miss_ack, 0);
    chk("rst_wr", bus.dc_wr, 0);
    chk("rst_ferr", bus.fill_err, 0);
    chk("rst_adr", bus.adr_o, 0);
    @(negedge clk) rst = 1'b0;
    fill(32'h0000_1234, 1'b0);
    chk("lat_single", ack_k, 6);
    chk("single_nwr", n_wr, 1);
    chk("single_wadr", wq[0], 32'h1220);
    chk("single_b0", last_wdat[127:96], 32'h1220);
    chk("single_b1", last_wdat[255:224], 32'h1230);
    fill(32'h0000_13F8, 1'b1);
    chk("lat_both", ack_k, 11);
    chk("strad_l0", wq[1], 32'h13E0);
    chk("strad_l1", wq[2], 32'h1400);
    junk_ack = 1'b1;
    fill(32'hFFFF_FFF0, 1'b1);
    junk_ack = 1'b0;
    chk("wrap_l0", wq[3], 32'hFFFF_FFE0);
    chk("wrap_l1", wq[4], 32'h0);
    chk("wrap_b1", last_wdat[255:224], 32'h10);
    w0 = n_wr;
    a0 = n_ack;
    err_en = 1'b1;
    err_adr = 32'h1410;
    start(32'h0000_13F8, 1'b1);
    wait_ack(30);
    chk("err_ferr", bus.fill_err, 1);
    chk("err_busy", bus.busy, 1);
    drop_req();
    err_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_nwr", n_wr - w0, 1);
    chk("err_wadr", wq[wq.size()-1], 32'h13E0);
    chk("err_nack", n_ack - a0, 1);
    chk("err_sticky", bus.fill_err, 1);
    fill(32'h0000_1234, 1'b0);
    chk("clr_ferr", bus.fill_err, 0);
    w0 = n_wr;
    c0 = n_cyc;
    stall = 1'b1;
    start(32'h0000_2000, 1'b0);
    wait_ack(1100);
    chk("to_ferr", bus.fill_err, 1);
    drop_req();
    stall = 1'b0;
    repeat (2) @(negedge clk);
    chk("to_cycles", n_cyc - c0, 1023);
    chk("to_nwr", n_wr - w0, 0);
    w0 = n_wr;
    a0 = n_ack;
    start(32'h0000_3000, 1'b0);
    repeat (5) @(posedge clk);
    #1 chk("pre_abort_wr", bus.dc_wr, 1);
    bus.abort = 1'b1;
    bus.miss_req = 1'b0;
    #1;
    chk("abort_wr", bus.dc_wr, 0);
    chk("abort_ack", bus.miss_ack, 0);
    @(posedge clk);
    #1 bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_ferr", bus.fill_err, 0);
    repeat (3) @(negedge clk);
    chk("abort_nwr", n_wr - w0, 0);
    chk("abort_nack", n_ack - a0, 0);
    start(32'h0000_4000, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("pre_rst_stb", bus.stb_o, 1);
    rst = 1'b1;
    bus.miss_req = 1'b0;
    #1;
    chk("arst_cyc", bus.cyc_o, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_adr", bus.adr_o, 0);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("arst_nwr", n_wr - w0, 0);
    chk("arst_nack", n_ack - a0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
